// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MA stage (master) and the memory (slave).
interface mem_access_stage_if #(
  parameter int NBITS = 32
);
  logic             o_mem_req;
  logic             o_mem_we;
  logic [NBITS-1:0] o_mem_addr;
  logic [3:0]       o_mem_be;
  logic [NBITS-1:0] o_mem_wdata;
  logic             i_mem_ack;
  logic [NBITS-1:0] i_mem_rdata;

  modport master (
    output o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    input  i_mem_ack, i_mem_rdata
  );

  modport slave (
    input  o_mem_req, o_mem_we, o_mem_addr, o_mem_be, o_mem_wdata,
    output i_mem_ack, i_mem_rdata
  );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: issues loads/stores on a req/ack bus, aligns and
// extends load data, and presents a registered write-back record. Upstream is
// stalled while a bus transaction is outstanding.
module mem_access_stage #(
  parameter int NBITS   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic [NBITS-1:0]   i_ALU_rslt,
  input  logic [NBITS-1:0]   i_eff_addr,
  input  logic [NBITS-1:0]   i_store_data,
  input  logic               i_flg_mem_op,
  input  logic               i_flg_mem_type,
  input  logic [1:0]         i_flg_mem_size,
  input  logic               i_flg_unsign,
  input  logic [4:0]         i_rd,
  input  logic [4:0]         i_rt,
  input  logic               i_flg_ALU_dst,
  output logic               o_stall,
  mem_access_stage_if.master bus,
  output logic               o_valid,
  output logic               o_wb_en,
  output logic [4:0]         o_wb_reg,
  output logic [NBITS-1:0]   o_wb_data,
  output logic               o_addr_err,
  output logic               o_bus_err
);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t           r_state;
  logic [7:0]       r_cnt;
  logic             r_type;
  logic [1:0]       r_size;
  logic             r_unsign;
  logic [4:0]       r_rt;
  logic [1:0]       r_off;

  logic [1:0]       w_size;
  logic             w_misalign;
  logic [3:0]       w_be;
  logic [NBITS-1:0] w_wdata;
  logic [NBITS-1:0] w_shifted;
  logic [NBITS-1:0] w_load;

  // Size code 10 is illegal and is handled exactly like a word access.
  assign w_size     = (i_flg_mem_size == 2'b10) ? 2'b11 : i_flg_mem_size;
  assign w_misalign = (w_size == 2'b01 && i_eff_addr[0]) ||
                      (w_size == 2'b11 && i_eff_addr[1:0] != 2'b00);
  assign o_stall    = (r_state == BUSY);

  // Per-lane store data replication and byte enables. Loads fetch the whole word
  // (all lanes enabled); the wanted lane is picked out when the data returns.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_lane
      assign w_wdata[8*gi +: 8] = (w_size == 2'b11) ? i_store_data[8*gi +: 8] :
                                  (w_size == 2'b01) ? i_store_data[8*(gi%2) +: 8] :
                                                      i_store_data[7:0];
      assign w_be[gi] = !i_flg_mem_type    ? 1'b1 :
                        (w_size == 2'b11)  ? 1'b1 :
                        (w_size == 2'b01)  ? (1'(gi/2) == i_eff_addr[1]) :
                                             (2'(gi) == i_eff_addr[1:0]);
    end
  endgenerate

  // Select the addressed lane of the returned word, truncate and extend it.
  assign w_shifted = bus.i_mem_rdata >> {r_off, 3'b000};
  always_comb begin
    w_load = w_shifted;
    case (r_size)
      2'b00:   w_load = r_unsign ? {{(NBITS-8){1'b0}}, w_shifted[7:0]}
                                 : {{(NBITS-8){w_shifted[7]}}, w_shifted[7:0]};
      2'b01:   w_load = r_unsign ? {{(NBITS-16){1'b0}}, w_shifted[15:0]}
                                 : {{(NBITS-16){w_shifted[15]}}, w_shifted[15:0]};
      default: w_load = w_shifted;
    endcase
  end

  // IDLE/BUSY controller with registered bus and write-back outputs.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state         <= IDLE;
      r_cnt           <= '0;
      r_type          <= 1'b0;
      r_size          <= 2'b00;
      r_unsign        <= 1'b0;
      r_rt            <= '0;
      r_off           <= 2'b00;
      bus.o_mem_req   <= 1'b0;
      bus.o_mem_we    <= 1'b0;
      bus.o_mem_addr  <= '0;
      bus.o_mem_be    <= '0;
      bus.o_mem_wdata <= '0;
      o_valid         <= 1'b0;
      o_wb_en         <= 1'b0;
      o_wb_reg        <= '0;
      o_wb_data       <= '0;
      o_addr_err      <= 1'b0;
      o_bus_err       <= 1'b0;
    end else begin
      o_valid    <= 1'b0;
      o_wb_en    <= 1'b0;
      o_addr_err <= 1'b0;
      o_bus_err  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_valid) begin
            if (!i_flg_mem_op) begin
              o_valid   <= 1'b1;
              o_wb_en   <= 1'b1;
              o_wb_reg  <= i_flg_ALU_dst ? i_rd : i_rt;
              o_wb_data <= i_ALU_rslt;
            end else if (w_misalign) begin
              o_valid    <= 1'b1;
              o_addr_err <= 1'b1;
              o_wb_data  <= '0;
            end else begin
              r_type          <= i_flg_mem_type;
              r_size          <= w_size;
              r_unsign        <= i_flg_unsign;
              r_rt            <= i_rt;
              r_off           <= i_eff_addr[1:0];
              r_cnt           <= '0;
              r_state         <= BUSY;
              bus.o_mem_req   <= 1'b1;
              bus.o_mem_we    <= i_flg_mem_type;
              bus.o_mem_addr  <= {i_eff_addr[NBITS-1:2], 2'b00};
              bus.o_mem_be    <= w_be;
              bus.o_mem_wdata <= w_wdata;
            end
          end
        end
        BUSY: begin
          if (bus.i_mem_ack || r_cnt == 8'(TIMEOUT - 1)) begin
            // An ack in the final allowed cycle still counts as a completion.
            r_state         <= IDLE;
            r_cnt           <= '0;
            bus.o_mem_req   <= 1'b0;
            bus.o_mem_we    <= 1'b0;
            bus.o_mem_be    <= '0;
            o_valid         <= 1'b1;
            o_wb_reg        <= r_rt;
            o_wb_data       <= '0;
            if (!bus.i_mem_ack) begin
              o_bus_err <= 1'b1;
            end else if (!r_type) begin
              o_wb_en   <= 1'b1;
              o_wb_data <= w_load;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomised self-checking bench for mem_access_stage with a behavioural model of
// alignment, byte enables, lane replication, load extension and timeout.
module tb_mem_access_stage;
  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid = 1'b0;
  logic [31:0] alu = '0, addr = '0, sdata = '0;
  logic        mem_op = 1'b0, mem_type = 1'b0, unsign = 1'b0, alu_dst = 1'b0;
  logic [1:0]  mem_size = 2'b00;
  logic [4:0]  rd = '0, rt = '0;
  logic        stall, o_valid, wb_en, addr_err, bus_err;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;

  int n_pass = 0;
  int n_total = 0;

  mem_access_stage_if #(.NBITS(32)) bus ();

  mem_access_stage #(.NBITS(32), .TIMEOUT(TMO)) dut (
    .i_clk(clk), .i_rst(rst_n), .i_valid(valid), .i_ALU_rslt(alu),
    .i_eff_addr(addr), .i_store_data(sdata), .i_flg_mem_op(mem_op),
    .i_flg_mem_type(mem_type), .i_flg_mem_size(mem_size), .i_flg_unsign(unsign),
    .i_rd(rd), .i_rt(rt), .i_flg_ALU_dst(alu_dst), .o_stall(stall), .bus(bus),
    .o_valid(o_valid), .o_wb_en(wb_en), .o_wb_reg(wb_reg), .o_wb_data(wb_data),
    .o_addr_err(addr_err), .o_bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: is the access misaligned for its size?
  function automatic bit ref_misalign(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'b00) return 1'b0;
    if (sz == 2'b01) return (a % 2) != 0;
    return (a % 4) != 0;
  endfunction

  function automatic logic [3:0] ref_be(input bit st, input logic [1:0] sz, input logic [31:0] a);
    if (!st || sz[1]) return 4'hF;
    if (sz == 2'b01) return 4'(3 << (a % 4));
    return 4'(1 << (a % 4));
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz[1]) return d;
    if (sz == 2'b01) return (d & 32'hFFFF) * 32'h0001_0001;
    return (d & 32'hFF) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input bit u, input logic [31:0] a,
                                           input logic [31:0] rdw);
    longint v, lim;
    v = longint'(rdw) / (longint'(1) << (8 * (a % 4)));
    if (sz[1]) return 32'(v);
    lim = (sz == 2'b01) ? 65536 : 256;
    v = v % lim;
    if (!u && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  // Present one EX/MA record, run it to completion and compare against the model.
  task automatic run_op(input bit m, input bit st, input logic [1:0] sz, input bit u,
                        input logic [31:0] a_alu, input logic [31:0] a, input logic [31:0] d,
                        input logic [4:0] r_d, input logic [4:0] r_t, input bit dst,
                        input logic [31:0] rdw, input int delay);
    bit acked = 1'b0;
    valid = 1'b1; mem_op = m; mem_type = st; mem_size = sz; unsign = u;
    alu = a_alu; addr = a; sdata = d; rd = r_d; rt = r_t; alu_dst = dst;
    step();
    if (!m) begin
      $display("op alu   data=%h rd=%0d rt=%0d dst=%0d", a_alu, r_d, r_t, dst);
      check_val("alu_valid", 32'(o_valid), 32'd1);
      check_val("alu_wb_en", 32'(wb_en), 32'd1);
      check_val("alu_wb_reg", 32'(wb_reg), 32'(dst ? r_d : r_t));
      check_val("alu_wb_data", wb_data, a_alu);
      check_val("alu_stall", 32'(stall), 32'd0);
      check_val("alu_req", 32'(bus.o_mem_req), 32'd0);
    end else if (ref_misalign(sz, a)) begin
      $display("op misal st=%0d size=%0d addr=%h", st, sz, a);
      check_val("mis_valid", 32'(o_valid), 32'd1);
      check_val("mis_addr_err", 32'(addr_err), 32'd1);
      check_val("mis_wb_en", 32'(wb_en), 32'd0);
      check_val("mis_req", 32'(bus.o_mem_req), 32'd0);
      check_val("mis_stall", 32'(stall), 32'd0);
    end else begin
      check_val("req", 32'(bus.o_mem_req), 32'd1);
      check_val("we", 32'(bus.o_mem_we), 32'(st));
      check_val("mem_addr", bus.o_mem_addr, a & 32'hFFFF_FFFC);
      check_val("be", 32'(bus.o_mem_be), 32'(ref_be(st, sz, a)));
      if (st) check_val("wdata", bus.o_mem_wdata, ref_wdata(sz, d));
      for (int b = 0; b < TMO; b++) begin
        check_val("busy_stall", 32'(stall), 32'd1);
        check_val("busy_req", 32'(bus.o_mem_req), 32'd1);
        check_val("busy_addr", bus.o_mem_addr, a & 32'hFFFF_FFFC);
        if (b == delay) begin
          bus.i_mem_ack = 1'b1;
          bus.i_mem_rdata = rdw;
        end
        step();
        bus.i_mem_ack = 1'b0;
        bus.i_mem_rdata = $urandom;
        if (b == delay) begin
          acked = 1'b1;
          break;
        end
      end
      $display("op mem   st=%0d size=%0d u=%0d addr=%h delay=%0d acked=%0d wb=%h", st, sz, u, a,
               delay, acked, wb_data);
      check_val("done_valid", 32'(o_valid), 32'd1);
      check_val("done_req", 32'(bus.o_mem_req), 32'd0);
      check_val("done_stall", 32'(stall), 32'd0);
      check_val("done_bus_err", 32'(bus_err), 32'(!acked));
      check_val("done_wb_en", 32'(wb_en), 32'(acked && !st));
      if (acked && !st) begin
        check_val("load_reg", 32'(wb_reg), 32'(r_t));
        check_val("load_data", wb_data, ref_load(sz, u, a, rdw));
      end
      if (acked && st) check_val("store_wb_data", wb_data, 32'd0);
    end
    valid = 1'b0;
  endtask

  task automatic idle_cycle();
    bus.i_mem_ack = 1'($urandom_range(0, 1));
    step();
    bus.i_mem_ack = 1'b0;
    $display("op idle");
    check_val("idle_valid", 32'(o_valid), 32'd0);
    check_val("idle_wb_en", 32'(wb_en), 32'd0);
    check_val("idle_req", 32'(bus.o_mem_req), 32'd0);
  endtask

  initial begin
    bus.i_mem_ack = 1'b0;
    bus.i_mem_rdata = '0;
    #12;
    check_val("rst_valid", 32'(o_valid), 32'd0);
    check_val("rst_req", 32'(bus.o_mem_req), 32'd0);
    check_val("rst_stall", 32'(stall), 32'd0);
    check_val("rst_wb_data", wb_data, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    step();

    // Directed cases.
    run_op(0, 0, 2'b00, 0, 32'h0000_1234, 32'h0, 32'h0, 5'd5, 5'd7, 1, 32'h0, 0);
    run_op(1, 0, 2'b00, 0, 32'h0, 32'h103, 32'h0, 5'd1, 5'd9, 0, 32'h80FF_1234, 2);
    run_op(1, 0, 2'b01, 1, 32'h0, 32'h102, 32'h0, 5'd1, 5'd10, 0, 32'h80FF_1234, 1);
    run_op(1, 0, 2'b01, 0, 32'h0, 32'h100, 32'h0, 5'd1, 5'd11, 0, 32'h80FF_1234, 0);
    run_op(1, 1, 2'b01, 0, 32'h0, 32'h202, 32'hDEAD_BEEF, 5'd1, 5'd12, 0, 32'h0, 0);
    run_op(1, 0, 2'b11, 0, 32'h0, 32'h101, 32'h0, 5'd1, 5'd13, 0, 32'h0, 0);
    run_op(1, 0, 2'b11, 0, 32'h0, 32'h300, 32'h0, 5'd1, 5'd14, 0, 32'h0, 99);
    run_op(1, 0, 2'b11, 0, 32'h0, 32'h304, 32'h0, 5'd1, 5'd15, 0, 32'hCAFE_F00D, TMO - 1);
    idle_cycle();

    // Reset asserted while a request is outstanding.
    valid = 1'b1; mem_op = 1'b1; mem_type = 1'b0; mem_size = 2'b11; addr = 32'h400;
    step();
    valid = 1'b0;
    check_val("pre_rst_req", 32'(bus.o_mem_req), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_val("async_rst_req", 32'(bus.o_mem_req), 32'd0);
    check_val("async_rst_stall", 32'(stall), 32'd0);
    check_val("async_rst_valid", 32'(o_valid), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle_cycle();

    // Randomised sequence, mostly back-to-back.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra[1:0] = 2'b00;
      run_op(($urandom_range(0, 4) != 0), 1'($urandom), 2'($urandom), 1'($urandom), $urandom,
             ra, $urandom, 5'($urandom), 5'($urandom), 1'($urandom), $urandom,
             int'($urandom_range(0, TMO + 1)));
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
